// File: rtl/fetch_sequencer.sv
// Fetches a 16-bit instruction as two byte reads (pc, pc+1) and presents it on ir_d with a one-cycle ir_en strobe; FETCH_SEQUENCER_PERF_EN adds the fetch_count counter.
// Latency 3 edges from go to issue with zero-wait memory; mem_ready low holds the read, stall holds the word in ISSUE, jump aborts to IDLE.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nclr,
  input  logic                  go,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_rdata,
  output logic [15:0]           ir_d,
  output logic                  ir_en,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            lo_byte;
  logic [ADDR_WIDTH-1:0] pc_inc1;
  logic [ADDR_WIDTH-1:0] pc_inc2;

  assign pc_inc1 = pc + ADDR_WIDTH'(1);
  assign pc_inc2 = pc + ADDR_WIDTH'(2);

  // The low byte is staged and ir_d is written whole when the high byte lands,
  // so ir_d never moves during the ir_en cycle or the cycle after it.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state    <= IDLE;
      pc       <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      lo_byte  <= '0;
      ir_d     <= '0;
      ir_en    <= 1'b0;
      busy     <= 1'b0;
`ifdef FETCH_SEQUENCER_PERF_EN
      fetch_count <= '0;
`endif
    end else begin
      ir_en <= 1'b0;
      if (jump) begin
        pc      <= jump_addr;
        mem_req <= 1'b0;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (go && !stall) begin
              state    <= LO;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end
          end
          LO: begin
            if (mem_ready) begin
              lo_byte  <= mem_rdata;
              mem_addr <= pc_inc1;
              state    <= HI;
            end
          end
          HI: begin
            if (mem_ready) begin
              ir_d    <= {mem_rdata, lo_byte};
              mem_req <= 1'b0;
              state   <= ISSUE;
            end
          end
          ISSUE: begin
            if (!stall) begin
              ir_en <= 1'b1;
              pc    <= pc_inc2;
`ifdef FETCH_SEQUENCER_PERF_EN
              fetch_count <= fetch_count + 16'd1;
`endif
              if (go) begin
                state    <= LO;
                mem_req  <= 1'b1;
                mem_addr <= pc_inc2;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef FETCH_SEQUENCER_PERF_EN
  assign fetch_count = '0;
`endif

endmodule
